// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_BYTES      = 1;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StWrite,
        StCsum,
        StDone,
        StErr
    } loader_state_e;

    // Total stream length in bytes for an n-word image (length byte plus payload).
    function automatic int unsigned stream_bytes(input int unsigned n);
        return LEN_BYTES + BYTES_PER_WORD * n;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs bytes into a 32-bit little-endian word; byte k lands in bits [8k+7:8k].
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last_byte
);

    localparam int unsigned CntW = $clog2(BYTES_PER_WORD);

    logic [CntW-1:0] cnt_q;
    logic [31:0]     word_q;

    // Byte counter and assembly register; the counter wraps naturally after each word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clr) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (shift_en) begin
            word_q[{cnt_q, 3'b000} +: 8] <= byte_in;
            cnt_q                        <= cnt_q + CntW'(1);
        end
    end

    assign word      = word_q;
    assign last_byte = (cnt_q == CntW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// Streams a length-prefixed byte image into instruction memory while holding the CPU.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module inst_mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_written
);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] ww_q, ww_d;
    logic [ADDR_W-1:0] ww_inc;
    logic              accept;
    logic              pk_clr, pk_shift, pk_last;
    logic [31:0]       pk_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .shift_en  (pk_shift),
        .byte_in   (byte_in),
        .word      (pk_word),
        .last_byte (pk_last)
    );

    assign accept = byte_valid && byte_ready;
    assign ww_inc = ww_q + ADDR_W'(1);

    // State, length and word-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            ww_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ww_q    <= ww_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Next-state logic and packer control.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        ww_d     = ww_q;
        pk_clr   = 1'b0;
        pk_shift = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StLen;
                    ww_d    = '0;
                    pk_clr  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            StLen: begin
                if (accept) begin
                    if (byte_in == 8'd0 || {24'd0, byte_in} > DEPTH) begin
                        state_d = StErr;
                    end else begin
                        len_d   = ADDR_W'(byte_in);
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    pk_shift = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d   = csum_q ^ byte_in;
`endif
                    if (pk_last) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                ww_d = ww_inc;
                if (ww_inc == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = StCsum;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StData;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCsum: begin
                if (accept) begin
                    state_d = (byte_in == csum_q) ? StDone : StErr;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Moore-style status outputs decoded from the current state.
    always_comb begin
        byte_ready = 1'b0;
        cpu_hold   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state_q)
            StLen, StData: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                busy       = 1'b1;
            end
            StWrite: begin
                cpu_hold = 1'b1;
                busy     = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            StCsum: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
            end
`endif
            StDone:  done  = 1'b1;
            StErr:   error = 1'b1;
            default: ;
        endcase
    end

    assign wr_en         = (state_q == StWrite);
    assign wr_addr       = ww_q;
    assign wr_data       = pk_word;
    assign words_written = ww_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader.
module tb_inst_mem_loader;
    import loader_pkg::*;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] words_written;

    int n_checks = 0;
    int n_fail   = 0;
    bit hold_valid = 1'b0;
    logic [7:0] tb_csum;
    logic [31:0] words_q[$];
    logic [31:0] log_data[$];
    logic [ADDR_W-1:0] log_addr[$];
    logic [7:0] bad_lens [2] = '{8'h00, 8'h41};

    inst_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .cpu_hold      (cpu_hold),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    // Write monitor: logs every strobe and checks the stream is stalled during it.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            n_checks++;
            if (byte_ready !== 1'b0 || wr_addr >= ADDR_W'(DEPTH)) begin
                n_fail++;
                $display("FAIL write_stall: ready=%b addr=%0d, required ready=0 addr<%0d",
                         byte_ready, wr_addr, DEPTH);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (byte_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: byte %h not accepted, ready=%b required 1", b, byte_ready);
        end else begin
            @(posedge clk);
            #1;
            if (!hold_valid) byte_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            tb_csum ^= w[8*i +: 8];
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load();
        tb_csum = 8'h00;
        send_byte(8'(words_q.size()));
        foreach (words_q[i]) send_word(words_q[i]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(tb_csum);
`endif
    endtask

    task automatic wait_end(output bit timed_out);
        int budget = 4 * int'(stream_bytes(32'(words_q.size()))) + 20;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1 || error === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({byte_ready, wr_en, cpu_hold, busy, done, error} !== 6'b0 || wr_addr !== '0 ||
            wr_data !== 32'h0 || words_written !== '0) begin
            n_fail++;
            $display("FAIL reset_in: ctl=%b addr=%0d data=%h ww=%0d, required all zero",
                     {byte_ready, wr_en, cpu_hold, busy, done, error}, wr_addr, wr_data,
                     words_written);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({byte_ready, wr_en, cpu_hold, busy, done, error} !== 6'b0 || words_written !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: ctl=%b ww=%0d, required all zero",
                     {byte_ready, wr_en, cpu_hold, busy, done, error}, words_written);
        end
    endtask

    task automatic test_basic();
        bit to;
        log_addr.delete();
        log_data.delete();
        words_q = {32'h00002083, 32'h00402103};
        pulse_start();
        n_checks++;
        if ({cpu_hold, busy, byte_ready, done} !== 4'b1110) begin
            n_fail++;
            $display("FAIL basic_len: hold/busy/ready/done=%b required 1110",
                     {cpu_hold, busy, byte_ready, done});
        end
        send_byte(8'h02);
        send_byte(8'h83);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 8'd0 || wr_data !== 32'h00002083) begin
            n_fail++;
            $display("FAIL basic_latency: en=%b addr=%0d data=%h required 1 0 00002083",
                     wr_en, wr_addr, wr_data);
        end
        send_word(32'h00402103);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hC1);
`endif
        wait_end(to);
        n_checks++;
        if (to || {done, error, cpu_hold, busy} !== 4'b1000 || words_written !== 8'd2) begin
            n_fail++;
            $display("FAIL basic_done: timeout=%b done/err/hold/busy=%b ww=%0d required 0 1000 2",
                     to, {done, error, cpu_hold, busy}, words_written);
        end
        n_checks++;
        if (log_addr.size() != 2 || log_addr[0] !== 8'd0 || log_data[0] !== 32'h00002083 ||
            log_addr[1] !== 8'd1 || log_data[1] !== 32'h00402103) begin
            n_fail++;
            $display("FAIL basic_writes: %0d writes, last addr=%0d data=%h, required 2 ending 1 00402103",
                     log_addr.size(), log_addr[$], log_data[$]);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [31:0] exp[3] = '{32'hDEADBEEF, 32'h12345678, 32'h00000013};
        log_addr.delete();
        log_data.delete();
        words_q = {32'hDEADBEEF, 32'h12345678, 32'h00000013};
        hold_valid = 1'b1;
        pulse_start();
        run_load();
        wait_end(to);
        n_checks++;
        if (to || done !== 1'b1 || byte_ready !== 1'b0 || words_written !== 8'd3) begin
            n_fail++;
            $display("FAIL bp_done: timeout=%b done=%b ready=%b ww=%0d required 0 1 0 3",
                     to, done, byte_ready, words_written);
        end
        hold_valid = 1'b0;
        byte_valid = 1'b0;
        n_checks++;
        if (log_addr.size() != 3) begin
            n_fail++;
            $display("FAIL bp_count: %0d writes required 3", log_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL bp_word%0d: addr=%0d data=%h required %0d %h",
                             i, log_addr[i], log_data[i], i, exp[i]);
                end
            end
        end
    endtask

    task automatic test_bad_len();
        bit to;
        foreach (bad_lens[k]) begin
            log_addr.delete();
            log_data.delete();
            words_q = {};
            pulse_start();
            send_byte(bad_lens[k]);
            wait_end(to);
            n_checks++;
            if (to || {error, done, cpu_hold, busy} !== 4'b1000 || log_addr.size() != 0 ||
                words_written !== 8'd0) begin
                n_fail++;
                $display("FAIL bad_len_%h: timeout=%b err/done/hold/busy=%b writes=%0d ww=%0d required 0 1000 0 0",
                         bad_lens[k], to, {error, done, cpu_hold, busy}, log_addr.size(),
                         words_written);
            end
        end
    endtask

    task automatic test_max_len();
        bit to;
        int bad = 0;
        log_addr.delete();
        log_data.delete();
        words_q = {};
        for (int i = 0; i < 64; i++) words_q.push_back({8'(i), 8'hA5, 8'(i), 8'h5A});
        pulse_start();
        run_load();
        wait_end(to);
        n_checks++;
        if (to || done !== 1'b1 || error !== 1'b0 || words_written !== 8'd64 ||
            log_addr.size() != 64) begin
            n_fail++;
            $display("FAIL max_len: timeout=%b done=%b err=%b ww=%0d writes=%0d required 0 1 0 64 64",
                     to, done, error, words_written, log_addr.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== {8'(i), 8'hA5, 8'(i), 8'h5A})
                    bad++;
            end
            n_checks++;
            if (bad != 0 || log_addr[63] !== 8'd63) begin
                n_fail++;
                $display("FAIL max_len_data: %0d bad words, last addr=%0d required 0 63",
                         bad, log_addr[63]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        log_addr.delete();
        log_data.delete();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({byte_ready, wr_en, cpu_hold, busy, done, error} !== 6'b0 || wr_addr !== '0 ||
            wr_data !== 32'h0 || words_written !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: ctl=%b addr=%0d data=%h ww=%0d required all zero",
                     {byte_ready, wr_en, cpu_hold, busy, done, error}, wr_addr, wr_data,
                     words_written);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (log_addr.size() != 0 || byte_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_nowrite: writes=%0d ready=%b hold=%b required 0 0 0",
                     log_addr.size(), byte_ready, cpu_hold);
        end
        words_q = {32'hCAFEF00D};
        pulse_start();
        run_load();
        wait_end(to);
        n_checks++;
        if (to || done !== 1'b1 || log_addr.size() != 1 || log_addr[0] !== 8'd0 ||
            log_data[0] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL mid_reload: timeout=%b done=%b writes=%0d data=%h required 0 1 1 cafef00d",
                     to, done, log_addr.size(), log_data[0]);
        end
    endtask

    task automatic test_busy_restart();
        bit to;
        int bad = 0;
        log_addr.delete();
        log_data.delete();
        words_q = {32'hDDCCBBAA};
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || byte_ready !== 1'b1 || words_written !== 8'd0) begin
            n_fail++;
            $display("FAIL busy_start: busy=%b ready=%b ww=%0d required 1 1 0",
                     busy, byte_ready, words_written);
        end
        send_byte(8'hCC);
        send_byte(8'hDD);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        wait_end(to);
        n_checks++;
        if (to || done !== 1'b1 || log_addr.size() != 1 || log_data[0] !== 32'hDDCCBBAA) begin
            n_fail++;
            $display("FAIL busy_word: timeout=%b done=%b writes=%0d data=%h required 0 1 1 ddccbbaa",
                     to, done, log_addr.size(), log_data[0]);
        end
        log_addr.delete();
        log_data.delete();
        words_q = {};
        for (int i = 0; i < 9; i++) words_q.push_back(32'h0A000000 | 32'(i * 17));
        pulse_start();
        n_checks++;
        if (done !== 1'b0 || words_written !== 8'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: done=%b ww=%0d busy=%b required 0 0 1",
                     done, words_written, busy);
        end
        run_load();
        wait_end(to);
        n_checks++;
        if (to || done !== 1'b1 || words_written !== 8'd9 || log_addr.size() != 9) begin
            n_fail++;
            $display("FAIL restart_done: timeout=%b done=%b ww=%0d writes=%0d required 0 1 9 9",
                     to, done, words_written, log_addr.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== (32'h0A000000 | 32'(i * 17)))
                    bad++;
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL restart_data: %0d bad words required 0", bad);
            end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bit to;
        logic [7:0] sums [2] = '{8'hA3, 8'h00};
        foreach (sums[k]) begin
            log_addr.delete();
            log_data.delete();
            words_q = {32'h00002083};
            pulse_start();
            send_byte(8'h01);
            send_byte(8'h83);
            send_byte(8'h20);
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(sums[k]);
            wait_end(to);
            n_checks++;
            if (to || done !== (k == 0) || error !== (k != 0) || log_addr.size() != 1 ||
                log_addr[0] !== 8'd0 || log_data[0] !== 32'h00002083) begin
                n_fail++;
                $display("FAIL csum_%h: timeout=%b done=%b err=%b writes=%0d data=%h",
                         sums[k], to, done, error, log_addr.size(), log_data[0]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_bad_len();
        test_max_len();
        test_reset_mid();
        test_busy_restart();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
